path_raster_buffer: RTL and testbench

PATH_RASTER_BUFFER -- requirements
Module: path_raster_buffer

---
 rtl/path_raster_buffer.sv | 151 +++++++++++++++
 tb/tb_path_raster_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_raster_buffer.sv
// Path raster buffer: three GRID x GRID bitmaps filled by a path search
// and read back by a display raster through a one-cycle query port.
module path_raster_buffer #(
   parameter int GRID = 40
) (
   input  logic        sync,
   input  logic        reset,
   input  logic        clear_req,
   input  logic        cell_valid,
   output logic        cell_ready,
   input  logic [5:0]  cell_x,
   input  logic [5:0]  cell_y,
   input  logic [1:0]  cell_kind,
   input  logic        path_done,
   input  logic [5:0]  gridx,
   input  logic [5:0]  gridy,
   output logic        draw_grid,
   output logic        draw_obstacle,
   output logic        draw_path,
   output logic        draw_unknown,
   output logic        busy,
   output logic [10:0] path_len,
   output logic        err
);

   typedef enum logic [1:0] {
      CLEAR,
      LOAD,
      SHOW
   } state_t;

   localparam logic [5:0] LIMIT = 6'(GRID);
   localparam logic [5:0] LAST  = 6'(GRID - 1);
   localparam logic [1:0] K_PATH = 2'b00;
   localparam logic [1:0] K_OBS  = 2'b01;
   localparam logic [1:0] K_EXPL = 2'b10;

   state_t     state;
   logic [5:0] row;

   logic [GRID-1:0] obs_map  [GRID];
   logic [GRID-1:0] path_map [GRID];
   logic [GRID-1:0] expl_map [GRID];

   logic       run;
   logic       cell_in;
   logic       legal;
   logic       wr;
   logic [5:0] cx;
   logic [5:0] cy;
   logic       obs_hit;
   logic       path_hit;

   // Out-of-grid coordinates are folded to 0 so array reads stay in range.
   assign run     = !reset && !clear_req;
   assign cell_in = (cell_x < LIMIT) && (cell_y < LIMIT);
   assign legal   = cell_in && (cell_kind != 2'b11);
   assign wr      = run && (state == LOAD) && cell_valid && legal;
   assign cx      = cell_in ? cell_x : 6'd0;
   assign cy      = cell_in ? cell_y : 6'd0;
   assign obs_hit  = obs_map[cy][cx];
   assign path_hit = path_map[cy][cx];

   always_ff @(posedge sync) begin
      if (run && (state == CLEAR)) begin
         obs_map[row]  <= '0;
         path_map[row] <= '0;
         expl_map[row] <= '0;
      end else if (wr) begin
         unique case (cell_kind)
            K_OBS:   obs_map[cy][cx]  <= 1'b1;
            K_PATH:  path_map[cy][cx] <= 1'b1;
            K_EXPL:  expl_map[cy][cx] <= 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge sync) begin
      if (reset || clear_req) begin
         state      <= CLEAR;
         row        <= '0;
         path_len   <= '0;
         err        <= 1'b0;
         busy       <= 1'b1;
         cell_ready <= 1'b0;
      end else begin
         unique case (state)
            CLEAR: begin
               if (row == LAST) begin
                  state      <= LOAD;
                  busy       <= 1'b0;
                  cell_ready <= 1'b1;
               end else begin
                  row <= row + 6'd1;
               end
            end
            LOAD: begin
               if (cell_valid) begin
                  if (!legal) begin
                     err <= 1'b1;
                  end else begin
                     if ((cell_kind == K_PATH && obs_hit) ||
                         (cell_kind == K_OBS && path_hit))
                        err <= 1'b1;
                     // Saturate so large grids cannot wrap the counter.
                     if (cell_kind == K_PATH && !path_hit &&
                         path_len != 11'h7ff)
                        path_len <= path_len + 11'd1;
                  end
               end
               if (path_done) begin
                  state      <= SHOW;
                  cell_ready <= 1'b0;
               end
            end
            SHOW:    ;
            default: ;
         endcase
      end
   end

   logic       q_in;
   logic [5:0] qx;
   logic [5:0] qy;
   logic       q_obs;
   logic       q_path;
   logic       q_expl;

   assign q_in   = (gridx < LIMIT) && (gridy < LIMIT) && (state != CLEAR);
   assign qx     = q_in ? gridx : 6'd0;
   assign qy     = q_in ? gridy : 6'd0;
   assign q_obs  = obs_map[qy][qx];
   assign q_path = path_map[qy][qx];
   assign q_expl = expl_map[qy][qx];

   always_ff @(posedge sync) begin
      if (reset) begin
         draw_grid     <= 1'b0;
         draw_obstacle <= 1'b0;
         draw_path     <= 1'b0;
         draw_unknown  <= 1'b0;
      end else begin
         draw_grid     <= q_in;
         draw_obstacle <= q_in && q_obs;
         draw_path     <= q_in && !q_obs && q_path;
         draw_unknown  <= q_in && !(q_obs || q_path || q_expl);
      end
   end

endmodule

// File: tb/tb_path_raster_buffer.sv
// Directed bench for path_raster_buffer: reset/clear timing, cell loading,
// illegal cells, conflicts, clear priority and query latency.
module tb_path_raster_buffer;

   logic        sync = 1'b0;
   logic        reset;
   logic        clear_req;
   logic        cell_valid;
   logic        cell_ready;
   logic [5:0]  cell_x;
   logic [5:0]  cell_y;
   logic [1:0]  cell_kind;
   logic        path_done;
   logic [5:0]  gridx;
   logic [5:0]  gridy;
   logic        draw_grid;
   logic        draw_obstacle;
   logic        draw_path;
   logic        draw_unknown;
   logic        busy;
   logic [10:0] path_len;
   logic        err;

   int checks = 0;
   int failures = 0;
   int hi;

   path_raster_buffer #(.GRID(40)) dut (
      .sync(sync),
      .reset(reset),
      .clear_req(clear_req),
      .cell_valid(cell_valid),
      .cell_ready(cell_ready),
      .cell_x(cell_x),
      .cell_y(cell_y),
      .cell_kind(cell_kind),
      .path_done(path_done),
      .gridx(gridx),
      .gridy(gridy),
      .draw_grid(draw_grid),
      .draw_obstacle(draw_obstacle),
      .draw_path(draw_path),
      .draw_unknown(draw_unknown),
      .busy(busy),
      .path_len(path_len),
      .err(err)
   );

   always #5 sync = ~sync;

   logic [3:0] dv;
   assign dv = {draw_grid, draw_obstacle, draw_path, draw_unknown};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sync);
      #1;
   endtask

   task automatic send(input logic [5:0] x, input logic [5:0] y,
                       input logic [1:0] k);
      cell_x = x;
      cell_y = y;
      cell_kind = k;
      cell_valid = 1'b1;
      step();
      cell_valid = 1'b0;
   endtask

   task automatic query(input logic [5:0] x, input logic [5:0] y);
      gridx = x;
      gridy = y;
      step();
   endtask

   task automatic run_clear(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         step();
         if (busy) cnt++;
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_req = 1'b0;
      cell_valid = 1'b0;
      cell_x = '0;
      cell_y = '0;
      cell_kind = '0;
      path_done = 1'b0;
      gridx = '0;
      gridy = '0;

      step();
      reset = 1'b0;
      chk("rst_busy", busy, 1);
      chk("rst_ready", cell_ready, 0);
      chk("rst_len", path_len, 0);
      chk("rst_err", err, 0);
      chk("rst_draw", dv, 4'b0000);
      run_clear(39, hi);
      chk("clr_busy_cycles", hi, 39);
      chk("clr_ready_low", cell_ready, 0);
      step();
      chk("load_ready", cell_ready, 1);
      chk("load_busy", busy, 0);
      query(0, 0);
      chk("q00_empty", dv, 4'b1001);

      send(0, 0, 2'b00);
      send(1, 1, 2'b00);
      send(1, 1, 2'b00);
      send(5, 5, 2'b01);
      chk("len_dup", path_len, 2);
      chk("err_clean", err, 0);
      path_done = 1'b1;
      step();
      path_done = 1'b0;
      chk("show_ready", cell_ready, 0);
      query(1, 1);
      chk("q11_path", dv, 4'b1010);
      query(5, 5);
      chk("q55_obs", dv, 4'b1100);
      query(0, 0);
      chk("q00_path", dv, 4'b1010);
      send(9, 9, 2'b00);
      chk("show_frozen_len", path_len, 2);
      query(9, 9);
      chk("show_frozen_map", dv, 4'b1001);

      gridx = 39;
      gridy = 39;
      step();
      gridx = 63;
      gridy = 0;
      chk("q3939", dv, 4'b1001);
      step();
      chk("q630_off", dv, 4'b0000);

      gridx = 0;
      gridy = 0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      chk("creq_busy", busy, 1);
      chk("creq_len", path_len, 0);
      chk("creq_ready", cell_ready, 0);
      step();
      chk("clear_draw_off", dv, 4'b0000);
      run_clear(38, hi);
      chk("creq_busy_cycles", hi, 38);
      step();
      chk("creq_load", cell_ready, 1);

      send(4, 4, 2'b00);
      chk("p44_len", path_len, 1);
      chk("p44_err", err, 0);
      send(4, 4, 2'b01);
      chk("conflict_err", err, 1);
      chk("conflict_len", path_len, 1);
      send(4, 4, 2'b00);
      chk("dup44_len", path_len, 1);
      query(4, 4);
      chk("q44_obs_prio", dv, 4'b1100);
      query(1, 1);
      chk("q11_cleared", dv, 4'b1001);

      cell_x = 6;
      cell_y = 6;
      cell_kind = 2'b00;
      cell_valid = 1'b1;
      path_done = 1'b1;
      clear_req = 1'b1;
      step();
      cell_valid = 1'b0;
      path_done = 1'b0;
      clear_req = 1'b0;
      chk("prio_busy", busy, 1);
      chk("prio_len", path_len, 0);
      chk("prio_err", err, 0);
      chk("prio_ready", cell_ready, 0);
      run_clear(39, hi);
      chk("prio_busy_cycles", hi, 39);
      step();
      chk("prio_load", cell_ready, 1);
      query(6, 6);
      chk("q66_unwritten", dv, 4'b1001);
      query(4, 4);
      chk("q44_cleared", dv, 4'b1001);

      send(40, 3, 2'b00);
      chk("oob_err", err, 1);
      chk("oob_len", path_len, 0);
      send(3, 3, 2'b11);
      chk("rsv_err", err, 1);
      chk("rsv_len", path_len, 0);
      query(3, 3);
      chk("q33_unwritten", dv, 4'b1001);
      query(0, 3);
      chk("q03_unwritten", dv, 4'b1001);
      send(2, 2, 2'b00);
      chk("p22_len", path_len, 1);
      chk("err_sticky", err, 1);

      cell_x = 2;
      cell_y = 7;
      cell_kind = 2'b10;
      cell_valid = 1'b1;
      path_done = 1'b1;
      step();
      cell_valid = 1'b0;
      path_done = 1'b0;
      chk("done_show_ready", cell_ready, 0);
      chk("done_show_busy", busy, 0);
      query(2, 7);
      chk("q27_explored", dv, 4'b1000);

      cell_x = 8;
      cell_y = 8;
      cell_kind = 2'b00;
      cell_valid = 1'b1;
      path_done = 1'b1;
      clear_req = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      cell_valid = 1'b0;
      path_done = 1'b0;
      clear_req = 1'b0;
      chk("rst2_busy", busy, 1);
      chk("rst2_len", path_len, 0);
      chk("rst2_err", err, 0);
      chk("rst2_ready", cell_ready, 0);
      chk("rst2_draw", dv, 4'b0000);
      run_clear(20, hi);
      chk("rst2_busy_cycles", hi, 20);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      run_clear(39, hi);
      chk("restart_busy_cycles", hi, 39);
      step();
      chk("restart_load", cell_ready, 1);
      query(8, 8);
      chk("q88_unwritten", dv, 4'b1001);
      query(2, 7);
      chk("q27_cleared", dv, 4'b1001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
